// File: rtl/exe_stage.sv
// EXE stage: ALU, same-cycle branch resolution and the EXE/MEM output register.
// Define EXE_MULDIV_EN to add the iterative shift-add multiplier (cmd 1100) that stalls upstream.
module exe_stage #(
    parameter int len = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           valid_in,
    input  logic [len-1:0] pc_in,
    input  logic           wb_en_in,
    input  logic           mem_read_in,
    input  logic           mem_write_in,
    input  logic [1:0]     branch_type_in,
    input  logic [3:0]     exe_cmd_in,
    input  logic [31:0]    reg2_in,
    input  logic [31:0]    alu_inp1_in,
    input  logic [31:0]    alu_inp2_in,
    input  logic [4:0]     dest_in,
    output logic           branch_taken,
    output logic [len-1:0] branch_target,
    output logic           stall_out,
    output logic           valid_out,
    output logic           wb_en_out,
    output logic           mem_read_out,
    output logic           mem_write_out,
    output logic [31:0]    alu_result_out,
    output logic [31:0]    st_val_out,
    output logic [4:0]     dest_out
);

    localparam logic [3:0] CMD_MUL = 4'b1100;

    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic        br_cond;
    logic        ctrl_en;

    logic        valid_q, wb_en_q, mem_read_q, mem_write_q;
    logic [31:0] alu_result_q, st_val_q;
    logic [4:0]  dest_q;

`ifdef EXE_MULDIV_EN
    // MUL FSM: IDLE waiting for MUL | BUSY one multiplier bit per cycle | DONE product ready
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q, prod_d;
    logic        stall_mul;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        stall_mul = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in && exe_cmd_in == CMD_MUL) begin
                    stall_mul = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                    mcand_d   = alu_inp1_in;
                    mplier_d  = alu_inp2_in;
                    prod_d    = '0;
                end
            end
            BUSY: begin
                stall_mul = 1'b1;
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_out = reset & stall_mul;
`else
    assign stall_out = 1'b0;
`endif

    assign shamt = alu_inp2_in[4:0];

    always_comb begin
        alu_res = '0;
        case (exe_cmd_in)
            4'b0000: alu_res = alu_inp1_in + alu_inp2_in;
            4'b0010: alu_res = alu_inp1_in - alu_inp2_in;
            4'b0100: alu_res = alu_inp1_in & alu_inp2_in;
            4'b0101: alu_res = alu_inp1_in | alu_inp2_in;
            4'b0110: alu_res = ~(alu_inp1_in | alu_inp2_in);
            4'b0111: alu_res = alu_inp1_in ^ alu_inp2_in;
            4'b1000: alu_res = alu_inp1_in << shamt;
            4'b1001: alu_res = 32'($signed(alu_inp1_in) >>> shamt);
            4'b1010: alu_res = alu_inp1_in >> shamt;
`ifdef EXE_MULDIV_EN
            // Only observed when not stalled, i.e. in DONE with the product complete.
            CMD_MUL: alu_res = prod_q;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (branch_type_in)
            2'b01:   br_cond = (alu_inp1_in == 32'd0);
            2'b10:   br_cond = (alu_inp1_in != reg2_in);
            2'b11:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign branch_taken  = reset & valid_in & ~stall_out & br_cond;
    assign branch_target = pc_in + {alu_inp2_in[len-3:0], 2'b00};
    assign ctrl_en       = valid_in & (branch_type_in == 2'b00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_result_q <= '0;
            st_val_q     <= '0;
            dest_q       <= '0;
        end else if (stall_out) begin
            valid_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q      <= valid_in;
            wb_en_q      <= ctrl_en & wb_en_in;
            mem_read_q   <= ctrl_en & mem_read_in;
            mem_write_q  <= ctrl_en & mem_write_in;
            alu_result_q <= alu_res;
            st_val_q     <= reg2_in;
            dest_q       <= dest_in;
        end
    end

    assign valid_out      = valid_q;
    assign wb_en_out      = wb_en_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign alu_result_out = alu_result_q;
    assign st_val_out     = st_val_q;
    assign dest_out       = dest_q;

endmodule
